dram_timing_ctrl: RTL and testbench
===================================

Name: dram_timing_ctrl

Overview:
- Timing controller for the DRAM command FSM.
- Watches the FSM's current and next command state and times each timed state (ACTIVATE, READ, WRITE, PRECHARGE, REFRESH) with one shared down-counter.
- Returns per-state done flags that let the FSM advance.
- Owns the periodic refresh-interval counter and raises rf_req to the FSM.

Parameters:
- tRCD, 14: ACTIVATE occupancy in cycles (>=1).
- tRD, 20: READ occupancy, CL plus burst/2 (>=1).
- tWR, 30: WRITE occupancy, CWL plus burst/2 plus write recovery (>=1).
- tRP, 14: PRECHARGE occupancy (>=1).
- tRFC, 260: REFRESH occupancy (>=1).
- tREFI, 7800: refresh interval in cycles (>=2).
- CNT_W, 16: counter width; must hold max(all parameters).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- init_done  in  1  DRAM init complete; gates the refresh-interval counter.
- cmd_state  in  dram_state_t  current FSM state. Members used: ACTIVATE, READ, WRITE, PRECHARGE, REFRESH; all others are untimed.
- ncmd_state  in  dram_state_t  FSM next state.
- tACT_done  out  1  ACTIVATE time elapsed.
- tRD_done  out  1  READ time elapsed.
- tWR_done  out  1  WRITE time elapsed.
- tPRE_done  out  1  PRECHARGE time elapsed.
- tREF_done  out  1  REFRESH time elapsed.
- rf_req  out  1  refresh due.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - occupancy counter <= 0, interval counter <= tREFI-1, rf_req <= 0.
  - All done flags read 0 during and after reset until a timed state is entered.
- Load rule. At each edge, if ncmd_state is timed state X and either of the following holds, the counter loads T_X-1 (T_X is that state's parameter):
  - ncmd_state != cmd_state, or
  - cmd_state == X and X_done == 1 (back-to-back same command, e.g. READ->READ).
- Count rule: otherwise, if cmd_state is timed and counter != 0, counter decrements by 1.
- Hold rule: otherwise, counter holds. It never wraps below 0.
- Done flags are combinational from registered state: X_done = (cmd_state == X) && (counter == 0).
  - Result: the FSM occupies X for exactly T_X cycles when it leaves on the first done cycle.
  - If the FSM stalls in X, X_done stays high until cmd_state changes.
  - At most one done flag is high in any cycle.
- Untimed states (IDLE, INIT, etc.): all done flags 0; counter holds.
- Refresh interval counter:
  - Decrements only while init_done == 1 and rf_req == 0.
  - When it is 0 and rf_req == 0, rf_req <= 1 at the next edge.
  - rf_req stays high until an edge where cmd_state == REFRESH; at that edge rf_req <= 0 and the counter reloads tREFI-1.
  - If cmd_state == REFRESH while rf_req == 0 (forced refresh), the counter also reloads tREFI-1.
  - Reload takes priority over expiry in the same cycle.
- init_done low: interval counter holds and rf_req stays 0. The occupancy counter still operates; init sequencing may use PRECHARGE/REFRESH.
- RST mid-operation:
  - Any in-flight count is abandoned; the next state entry reloads from a full parameter value.
  - A pending rf_req is cleared.
- No combinational path from ncmd_state to any output.

Test Plan:
- Reset, then cmd_state=IDLE with ncmd_state=ACTIVATE for one cycle, then ACTIVATE held -> tACT_done first high on the 14th ACTIVATE cycle; all other done flags 0 throughout.
- Occupancy and stall checks:
  - READ entered, FSM leaves on done -> READ occupied exactly 20 cycles.
  - WRITE held for 40 cycles -> tWR_done rises on cycle 30 and stays high for cycles 30-40.
- READ->READ back-to-back (ncmd_state=READ on the tRD_done cycle) -> counter reloads to 19; the second tRD_done arrives 20 cycles after the first.
- Refresh request timing:
  - Override tREFI=50, init_done=1 from cycle 0 -> rf_req rises at the edge after 50 counting cycles.
  - Then holds for 5 cycles until cmd_state=REFRESH, deasserts at that edge.
  - tREF_done follows 260 cycles after REFRESH entry.
- init_done=0 for 100 cycles with tREFI=50 -> rf_req never asserts; after init_done rises, rf_req asserts 50 cycles later.
- Assert RST on cycle 5 of a PRECHARGE (counter=9) -> after release, with cmd_state still PRECHARGE, tPRE_done=0 and counter=0 holds; re-entering PRECHARGE yields done after a full 14 cycles; rf_req=0.

Source files
------------

// File: rtl/dram_timing_ctrl.sv
// Timing controller for the DRAM command FSM: one shared occupancy down-counter
// yields per-state done flags; a separate interval counter schedules refresh.

package dram_pkg;
    typedef enum logic [3:0] {
        IDLE,
        INIT,
        ACTIVATE,
        READ,
        WRITE,
        PRECHARGE,
        REFRESH,
        MRS
    } dram_state_t;
endpackage

module dram_timing_ctrl
    import dram_pkg::*;
#(
    parameter int unsigned tRCD  = 14,
    parameter int unsigned tRD   = 20,
    parameter int unsigned tWR   = 30,
    parameter int unsigned tRP   = 14,
    parameter int unsigned tRFC  = 260,
    parameter int unsigned tREFI = 7800,
    parameter int unsigned CNT_W = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        init_done,
    input  dram_state_t cmd_state,
    input  dram_state_t ncmd_state,
    output logic        tACT_done,
    output logic        tRD_done,
    output logic        tWR_done,
    output logic        tPRE_done,
    output logic        tREF_done,
    output logic        rf_req
);

    localparam logic [CNT_W-1:0] REFI_RELOAD = CNT_W'(tREFI - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] refi_q, refi_d;
    logic             rf_req_q, rf_req_d;
    logic             cnt_expired;
    logic             cur_done;

    function automatic logic is_timed(input dram_state_t s);
        is_timed = (s == ACTIVATE) || (s == READ) || (s == WRITE) ||
                   (s == PRECHARGE) || (s == REFRESH);
    endfunction

    function automatic logic [CNT_W-1:0] load_val(input dram_state_t s);
        case (s)
            ACTIVATE:  load_val = CNT_W'(tRCD - 1);
            READ:      load_val = CNT_W'(tRD - 1);
            WRITE:     load_val = CNT_W'(tWR - 1);
            PRECHARGE: load_val = CNT_W'(tRP - 1);
            REFRESH:   load_val = CNT_W'(tRFC - 1);
            default:   load_val = '0;
        endcase
    endfunction

    // armed_q marks that the counter was loaded by a real state entry, so a
    // zero left over from reset never reads as an elapsed interval.
    assign cnt_expired = armed_q && !RST && (cnt_q == '0);
    assign cur_done    = cnt_expired && is_timed(cmd_state);

    assign tACT_done = cnt_expired && (cmd_state == ACTIVATE);
    assign tRD_done  = cnt_expired && (cmd_state == READ);
    assign tWR_done  = cnt_expired && (cmd_state == WRITE);
    assign tPRE_done = cnt_expired && (cmd_state == PRECHARGE);
    assign tREF_done = cnt_expired && (cmd_state == REFRESH);
    assign rf_req    = rf_req_q;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (is_timed(ncmd_state) &&
            ((ncmd_state != cmd_state) || cur_done)) begin
            cnt_d   = load_val(ncmd_state);
            armed_d = 1'b1;
        end else if (is_timed(cmd_state) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Entering REFRESH services any pending request and restarts the interval.
    always_comb begin
        refi_d   = refi_q;
        rf_req_d = rf_req_q;
        if (cmd_state == REFRESH) begin
            rf_req_d = 1'b0;
            refi_d   = REFI_RELOAD;
        end else if (init_done && !rf_req_q) begin
            if (refi_q == '0) begin
                rf_req_d = 1'b1;
            end else begin
                refi_d = refi_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            refi_q   <= REFI_RELOAD;
            rf_req_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            refi_q   <= refi_d;
            rf_req_q <= rf_req_d;
        end
    end

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// Bench for dram_timing_ctrl: directed scenarios plus random FSM walks, checked
// against a model that counts cycles spent in each state.

module tb_dram_timing_ctrl;
    import dram_pkg::*;

    localparam int T_ACT  = 14;
    localparam int T_RD   = 20;
    localparam int T_WR   = 30;
    localparam int T_PRE  = 14;
    localparam int T_RFC  = 260;
    localparam int T_REFI = 50;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        init_done = 1'b0;
    dram_state_t cmd_state = IDLE;
    dram_state_t ncmd_state = IDLE;
    logic        tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req;

    dram_timing_ctrl #(.tREFI(T_REFI)) dut (
        .CLK(CLK), .RST(RST), .init_done(init_done),
        .cmd_state(cmd_state), .ncmd_state(ncmd_state),
        .tACT_done(tACT_done), .tRD_done(tRD_done), .tWR_done(tWR_done),
        .tPRE_done(tPRE_done), .tREF_done(tREF_done), .rf_req(rf_req)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Model: m_occ = cycles spent in the current timed state since entry or
    // back-to-back restart (0 = nothing entered since reset).
    int m_occ  = 0;
    bit m_rf   = 1'b0;
    int m_refc = 0;

    function automatic int t_of(input dram_state_t s);
        case (s)
            ACTIVATE:  return T_ACT;
            READ:      return T_RD;
            WRITE:     return T_WR;
            PRECHARGE: return T_PRE;
            REFRESH:   return T_RFC;
            default:   return 0;
        endcase
    endfunction

    function automatic bit m_done();
        return (t_of(cmd_state) > 0) && (m_occ > 0) && (m_occ >= t_of(cmd_state));
    endfunction

    function automatic logic [5:0] exp_vec();
        bit d;
        d = m_done();
        return {d && cmd_state == ACTIVATE, d && cmd_state == READ,
                d && cmd_state == WRITE, d && cmd_state == PRECHARGE,
                d && cmd_state == REFRESH, m_rf};
    endfunction

    task automatic check_outputs(input string tag);
        logic [5:0] obs, expv;
        obs  = {tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done, rf_req};
        expv = exp_vec();
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b (ACT,RD,WR,PRE,REF,rf)", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: present ncmd/init/reset, update the model at the edge, then
    // let cmd_state follow ncmd unless the FSM is stalled.
    task automatic step(input dram_state_t nxt, input bit ini, input bit r,
                        input bit stall, input string tag);
        bit pre_done;
        ncmd_state = nxt;
        init_done  = ini;
        RST        = r;
        @(posedge CLK);
        pre_done = m_done();
        if (r) begin
            m_occ = 0; m_rf = 1'b0; m_refc = 0;
        end else begin
            if (t_of(nxt) > 0 && (nxt != cmd_state || pre_done)) m_occ = 1;
            else if (t_of(cmd_state) > 0 && m_occ > 0 && m_occ < 1000) m_occ++;
            if (cmd_state == REFRESH) begin
                m_rf = 1'b0; m_refc = 0;
            end else if (ini && !m_rf) begin
                m_refc++;
                if (m_refc == T_REFI) m_rf = 1'b1;
            end
        end
        #1;
        if (!stall) cmd_state = nxt;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        int n, first, hi, anyrf, sel;
        dram_state_t nxt;
        bit stall;

        step(IDLE, 0, 1, 0, "reset0");
        step(IDLE, 0, 1, 0, "reset1");

        n = 0;
        do begin step(IDLE, 1, 0, 0, "refi_wait"); n++; end while (!rf_req && n < 80);
        check_int("rf_rise_cycles", n, T_REFI);
        repeat (5) step(IDLE, 1, 0, 0, "rf_hold");
        step(REFRESH, 1, 0, 0, "ref_enter");
        n = 0;
        do begin step(REFRESH, 1, 0, 0, "ref_occ"); n++; end while (!tREF_done && n < 300);
        check_int("tRFC_occupancy", n + 1, T_RFC);

        step(IDLE, 1, 0, 0, "idle");
        n = 0;
        do begin step(ACTIVATE, 1, 0, 0, "act_occ"); n++; end while (!tACT_done && n < 40);
        check_int("tRCD_occupancy", n, T_ACT);
        n = 0;
        do begin step(READ, 1, 0, 0, "rd_occ"); n++; end while (!tRD_done && n < 40);
        check_int("tRD_occupancy", n, T_RD);
        n = 0;
        do begin step(READ, 1, 0, 0, "rd_b2b"); n++; end while (!tRD_done && n < 40);
        check_int("tRD_back_to_back", n, T_RD);
        n = 0;
        do begin step(PRECHARGE, 1, 0, 0, "pre_occ"); n++; end while (!tPRE_done && n < 40);
        check_int("tRP_occupancy", n, T_PRE);

        first = 0; hi = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 1) step(WRITE, 1, 0, 0, "wr_enter");
            else        step(IDLE, 1, 0, 1, "wr_stall");
            if (tWR_done) begin
                hi++;
                if (first == 0) first = i;
            end
        end
        check_int("tWR_first_done", first, T_WR);
        check_int("tWR_done_cycles", hi, 40 - T_WR + 1);
        step(IDLE, 1, 0, 0, "wr_leave");

        step(IDLE, 0, 1, 0, "reset2");
        anyrf = 0;
        repeat (100) begin
            step(IDLE, 0, 0, 0, "init_low");
            if (rf_req) anyrf = 1;
        end
        check_int("rf_while_init_low", anyrf, 0);
        n = 0;
        do begin step(IDLE, 1, 0, 0, "init_high"); n++; end while (!rf_req && n < 80);
        check_int("rf_after_init", n, T_REFI);

        step(IDLE, 1, 0, 0, "idle2");
        repeat (5) step(PRECHARGE, 1, 0, 0, "pre_part");
        step(PRECHARGE, 1, 1, 0, "pre_reset");
        hi = 0;
        repeat (5) begin
            step(PRECHARGE, 1, 0, 0, "pre_after_rst");
            if (tPRE_done) hi++;
        end
        check_int("pre_done_after_rst", hi, 0);
        step(IDLE, 1, 0, 0, "idle3");
        n = 0;
        do begin step(PRECHARGE, 1, 0, 0, "pre_reenter"); n++; end while (!tPRE_done && n < 40);
        check_int("tRP_after_rst", n, T_PRE);

        for (int i = 0; i < 3000; i++) begin
            sel   = $urandom_range(0, 99);
            stall = 1'b0;
            nxt   = cmd_state;
            if (m_done() && sel < 60) begin
                nxt = dram_state_t'($urandom_range(0, 7));
            end else if (sel < 85) begin
                nxt = cmd_state;
            end else if (sel < 93) begin
                nxt = dram_state_t'($urandom_range(0, 7));
            end else begin
                sel   = $urandom_range(0, 2);
                nxt   = (sel == 0) ? IDLE : ((sel == 1) ? INIT : MRS);
                stall = 1'b1;
            end
            step(nxt, $urandom_range(0, 19) != 0, $urandom_range(0, 299) == 0, stall, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
